bcd_display_scan_ctrl: RTL

Sequences the four-digit seven-segment display from an 8-bit binary value. It replaces the combinational divide/modulo digit split with a multi-cycle shift-add-3 (double-dabble) BCD converter behind a load/busy handshake. It then time-multiplexes the four digits onto one shared segment bus with active-low anode selects and leading-zero blanking. It sits between the score/counter logic and the board display pins.

---
 rtl/bcd_display_scan_ctrl_if.sv | 21 ++
 rtl/bcd_display_scan_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan_ctrl_if.sv
// Handshake and display bus between the score logic, the scan controller and the board pins.
interface bcd_display_scan_ctrl_if #(
    parameter int VALUE_W = 8
);
    logic [VALUE_W-1:0] value;
    logic               load;
    logic               busy;
    logic               digits_valid;
    logic [6:0]         seg;
    logic [3:0]         an;

    modport master (
        output value, load,
        input  busy, digits_valid, seg, an
    );

    modport slave (
        input  value, load,
        output busy, digits_valid, seg, an
    );
endinterface

// File: rtl/bcd_display_scan_ctrl.sv
// Multi-cycle double-dabble BCD converter feeding a four-digit, active-low,
// time-multiplexed seven-segment scan with optional leading-zero blanking.
module bcd_display_scan_ctrl #(
    parameter int VALUE_W     = 8,
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input logic                    clk,
    input logic                    reset_n,
    bcd_display_scan_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(VALUE_W + 1);
    localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_COMMIT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [VALUE_W-1:0] r_bin;
    logic [15:0]        r_bcd;
    logic [15:0]        w_bcd_adj;
    logic [15:0]        r_dig;
    logic               r_busy;
    logic               r_valid;
    logic [REF_W-1:0]   r_ref;
    logic [1:0]         r_idx;
    logic [6:0]         r_seg;
    logic [3:0]         r_an;

    logic [15:0]        w_dig;
    logic               w_valid;
    logic [3:0]         w_cur;
    logic               w_blank3;
    logic               w_blank2;
    logic               w_blank1;
    logic               w_blank_cur;
    logic [6:0]         w_seg_nxt;
    logic [3:0]         w_an_nxt;

    function automatic logic [15:0] add3(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_load_acc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.load) begin
                    w_state_nxt = S_CONVERT;
                    w_load_acc  = 1'b1;
                end
            end
            S_CONVERT: begin
                if (r_cnt == CNT_W'(VALUE_W - 1))
                    w_state_nxt = S_COMMIT;
            end
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign w_bcd_adj = add3(r_bcd);

    // Conversion scratch is pure data; it is always reinitialised on an accepted load.
    always_ff @(posedge clk) begin
        if (w_load_acc) begin
            r_bin <= bus.value;
            r_bcd <= '0;
        end else if (r_state == S_CONVERT) begin
            {r_bcd, r_bin} <= {w_bcd_adj[14:0], r_bin, 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_dig   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            if (r_state == S_CONVERT)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
            if (r_state == S_COMMIT) begin
                r_dig   <= r_bcd;
                r_valid <= 1'b1;
            end
        end
    end

    // The committing value is forwarded so new digits reach seg on the cycle after COMMIT.
    assign w_dig   = (r_state == S_COMMIT) ? r_bcd : r_dig;
    assign w_valid = r_valid | (r_state == S_COMMIT);
    assign w_cur   = w_dig[{r_idx, 2'b00} +: 4];

    assign w_blank3 = BLANK_LZ && (w_dig[15:12] == 4'd0);
    assign w_blank2 = w_blank3 && (w_dig[11:8] == 4'd0);
    assign w_blank1 = w_blank2 && (w_dig[7:4] == 4'd0);

    always_comb begin
        w_blank_cur = 1'b0;
        case (r_idx)
            2'd1:    w_blank_cur = w_blank1;
            2'd2:    w_blank_cur = w_blank2;
            2'd3:    w_blank_cur = w_blank3;
            default: w_blank_cur = 1'b0;
        endcase
        if (w_valid) begin
            w_an_nxt  = ~(4'b0001 << r_idx);
            w_seg_nxt = w_blank_cur ? 7'h7F : seg7(w_cur);
        end else begin
            w_an_nxt  = 4'hF;
            w_seg_nxt = 7'h7F;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ref <= '0;
            r_idx <= 2'd0;
            r_seg <= 7'h7F;
            r_an  <= 4'hF;
        end else begin
            if (r_ref == REF_W'(REFRESH_DIV - 1)) begin
                r_ref <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_ref <= r_ref + 1'b1;
            end
            r_seg <= w_seg_nxt;
            r_an  <= w_an_nxt;
        end
    end

    assign bus.busy         = r_busy;
    assign bus.digits_valid = r_valid;
    assign bus.seg          = r_seg;
    assign bus.an           = r_an;
endmodule
